data_mem_responder: RTL and testbench

Data-memory responder for the single-cycle RV32I core. It sits on the far end of the core's load/store request path and serves LB/LH/LW/LBU/LHU/SB/SH/SW accesses over a valid/ready request/response handshake. Word-organised storage has byte lanes, programmable wait states, and error reporting for misaligned, out-of-range and illegal-width accesses. Each response carries a sign/zero-extended load result or a store completion.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_lane_align.sv | 54 +++++
 rtl/data_mem_responder.sv | 143 ++++++++++++++
 tb/tb_data_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared funct3 codes, word geometry and FSM encoding for the data-memory responder.
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store mask/replication, load extraction/extension,
// and width/alignment legality flags for one RV32I load/store.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]            i_funct3,
  input  logic [1:0]            i_addr,
  input  logic                  i_we,
  input  logic [31:0]           i_wdata,
  input  logic [31:0]           i_rd_word,
  output logic [WORD_BYTES-1:0] o_be,
  output logic [31:0]           o_wword,
  output logic [31:0]           o_ld_data,
  output logic                  o_misalign,
  output logic                  o_illegal
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rd_word[{i_addr, 3'b000} +: 8];
    w_half = i_rd_word[{i_addr[1], 4'b0000} +: 16];

    o_illegal  = i_we ? (i_funct3 > F3_W)
                      : !(i_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    // funct3[1:0] encodes the access size for every legal code
    o_misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                 ((i_funct3[1:0] == 2'b10) && (i_addr != 2'b00));

    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr;
        o_wword = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        o_wword = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wword = i_wdata;
      end
    endcase

    case (i_funct3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_ld_data = i_rd_word;
      F3_BU:   o_ld_data = {24'd0, w_byte};
      F3_HU:   o_ld_data = {16'd0, w_half};
      default: o_ld_data = 32'd0;
    endcase
  end
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request, programmable wait states, byte-lane
// word store and error reporting for the RV32I core's load/store path.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int         DEPTH     = 1 << (ADDR_W - 2);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t                r_state, w_state_next;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [31:0]           r_addr, r_wdata;
  logic [31:0]           r_rd_word;
  logic                  r_ld_ok, r_err;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_commit, w_accept;
  logic                  w_acc_we;
  logic [2:0]            w_acc_funct3;
  logic [31:0]           w_acc_addr, w_acc_wdata;
  logic [WORD_BYTES-1:0] w_be;
  logic [31:0]           w_wword, w_ld_data;
  logic                  w_misalign, w_illegal, w_range_err, w_acc_err;
  logic [ADDR_W-3:0]     w_idx;

  assign w_accept = (r_state == IDLE) && req_valid;

  // With no wait states the access commits on the accept edge, straight from the request.
  always_comb begin
    if (r_state == IDLE) begin
      w_acc_we     = req_we;
      w_acc_funct3 = req_funct3;
      w_acc_addr   = req_addr;
      w_acc_wdata  = req_wdata;
    end else begin
      w_acc_we     = r_we;
      w_acc_funct3 = r_funct3;
      w_acc_addr   = r_addr;
      w_acc_wdata  = r_wdata;
    end
  end

  mem_lane_align u_align (
    .i_funct3   (w_acc_funct3),
    .i_addr     (w_acc_addr[1:0]),
    .i_we       (w_acc_we),
    .i_wdata    (w_acc_wdata),
    .i_rd_word  (r_rd_word),
    .o_be       (w_be),
    .o_wword    (w_wword),
    .o_ld_data  (w_ld_data),
    .o_misalign (w_misalign),
    .o_illegal  (w_illegal)
  );

  assign w_range_err = |w_acc_addr[31:ADDR_W];
  assign w_acc_err   = w_illegal | w_misalign | w_range_err;
  assign w_idx       = w_acc_addr[ADDR_W-1:2];

  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: if (req_valid) begin
        w_state_next = (WAIT_CYC == 0) ? RESP : WAIT;
        w_commit     = (WAIT_CYC == 0);
      end
      WAIT: if (r_cnt == 4'd0) begin
        w_state_next = RESP;
        w_commit     = 1'b1;
      end
      RESP: if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    // A reset edge must never let a pending store reach the array
    if (rstd) w_commit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rstd) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rstd) begin
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_ld_ok  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt    <= WAIT_LOAD;
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_err   <= w_acc_err;
        r_ld_ok <= !w_acc_we && !w_acc_err;
      end
    end
  end

  // Byte-enabled word store with registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      if (w_acc_we && !w_acc_err) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
          if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
        end
      end
      r_rd_word <= r_mem[w_idx];
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = r_err;
  assign rsp_rdata = r_ld_ok ? w_ld_data : 32'd0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench: three responders (0, 1 and 3 wait states) driven by directed and random
// load/store traffic, checked against a byte-array reference model.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rstd       [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        rsp_valid  [3];
  logic        rsp_ready  [3];
  logic [31:0] rsp_rdata  [3];
  logic        rsp_err    [3];

  int          wc [3] = '{0, 1, 3};
  logic        tied [3];
  logic [7:0]  mm [3][256];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int WC = (gi == 0) ? 0 : (gi == 1) ? 1 : 3;
    data_mem_responder #(.ADDR_W(12), .WAIT_CYC(WC)) u_dut (
      .clk        (clk),
      .rstd       (rstd[gi]),
      .req_valid  (req_valid[gi]),
      .req_ready  (req_ready[gi]),
      .req_we     (req_we[gi]),
      .req_funct3 (req_funct3[gi]),
      .req_addr   (req_addr[gi]),
      .req_wdata  (req_wdata[gi]),
      .rsp_valid  (rsp_valid[gi]),
      .rsp_ready  (rsp_ready[gi]),
      .rsp_rdata  (rsp_rdata[gi]),
      .rsp_err    (rsp_err[gi])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: size from funct3, bytes little-endian, extension by funct3[2].
  task automatic model_access(input int d, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] ed, output logic ee);
    int sz;
    int base;
    logic [31:0] v;
    ed = 32'd0;
    sz = 1 << f3[1:0];
    ee = we ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 > 3'd5));
    if (!ee && ((a % sz) != 0)) ee = 1'b1;
    if (!ee && (a >= 32'h1000)) ee = 1'b1;
    if (!ee) begin
      base = int'(a);
      if (we) begin
        for (int k = 0; k < sz; k++) mm[d][base + k] = wd[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = mm[d][base + k];
        if (!f3[2] && (sz < 4) && v[8*sz - 1]) v = v | (32'hFFFF_FFFF << (8*sz));
        ed = v;
      end
    end
  endtask

  task automatic junk(input int d);
    req_valid[d]  = 1'b1;
    req_we[d]     = 1'($urandom_range(0, 1));
    req_funct3[d] = 3'($urandom_range(0, 7));
    req_addr[d]   = $urandom_range(0, 255);
    req_wdata[d]  = $urandom;
  endtask

  // Starts and ends at a negedge with the DUT idle.
  task automatic txn(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int bp, input string tag);
    logic [31:0] ed;
    logic        ee;
    int          lat;
    model_access(d, we, f3, a, wd, ed, ee);
    chk({tag, ":req_ready"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
    req_addr[d] = a; req_wdata[d] = wd;
    @(negedge clk);
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      chk({tag, ":busy"}, 32'(req_ready[d]), 32'd0);
      junk(d);
      @(negedge clk);
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'(1 + wc[d]));
    for (int i = 0; i < bp; i++) begin
      chk({tag, ":bp_valid"}, 32'(rsp_valid[d]), 32'd1);
      chk({tag, ":bp_rdata"}, rsp_rdata[d], ed);
      chk({tag, ":bp_ready"}, 32'(req_ready[d]), 32'd0);
      junk(d);
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
    chk({tag, ":valid"}, 32'(rsp_valid[d]), 32'd1);
    chk({tag, ":rdata"}, rsp_rdata[d], ed);
    chk({tag, ":err"}, 32'(rsp_err[d]), 32'(ee));
    last_rdata = rsp_rdata[d];
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    chk({tag, ":done_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, ":done_ready"}, 32'(req_ready[d]), 32'd1);
    if (!tied[d]) rsp_ready[d] = 1'b0;
    $display("txn %s dut=%0d we=%0d f3=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0d lat=%0d",
             tag, d, we, f3, a, wd, last_rdata, rsp_err[d], lat);
  endtask

  initial begin
    int c_prev;
    logic [31:0] a;
    logic [2:0]  f3;

    for (int d = 0; d < 3; d++) begin
      rstd[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'd0;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0; tied[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset:req_ready", 32'(req_ready[d]), 32'd1);
      chk("reset:rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset:rsp_rdata", rsp_rdata[d], 32'd0);
      chk("reset:rsp_err", 32'(rsp_err[d]), 32'd0);
      rstd[d] = 1'b0;
    end
    @(negedge clk);

    // Fill the low 256 bytes so every model byte is known
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 64; w++) txn(d, 1'b1, 3'd2, 32'(w * 4), $urandom, 0, "init");

    txn(1, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, "sw10");
    txn(1, 1'b0, 3'd2, 32'h10, 32'h0, 0, "lw10");
    chk("lw10_const", last_rdata, 32'hDEADBEEF);
    txn(1, 1'b0, 3'd0, 32'h13, 32'h0, 0, "lb13");
    chk("lb13_const", last_rdata, 32'hFFFFFFDE);
    txn(1, 1'b0, 3'd4, 32'h13, 32'h0, 0, "lbu13");
    chk("lbu13_const", last_rdata, 32'h000000DE);
    txn(1, 1'b0, 3'd1, 32'h12, 32'h0, 0, "lh12");
    chk("lh12_const", last_rdata, 32'hFFFFDEAD);
    txn(1, 1'b0, 3'd5, 32'h10, 32'h0, 0, "lhu10");
    chk("lhu10_const", last_rdata, 32'h0000BEEF);
    txn(1, 1'b1, 3'd0, 32'h11, 32'h000000AA, 0, "sb11");
    txn(1, 1'b0, 3'd2, 32'h10, 32'h0, 0, "lw10_sb");
    chk("lw10_sb_const", last_rdata, 32'hDEADAAEF);
    txn(1, 1'b0, 3'd2, 32'h12, 32'h0, 0, "lw12_mis");
    txn(1, 1'b1, 3'd1, 32'h21, 32'h0000BEEF, 0, "sh21_mis");
    txn(1, 1'b0, 3'd2, 32'h20, 32'h0, 0, "lw20");
    txn(1, 1'b0, 3'd3, 32'h20, 32'h0, 0, "ld_f3_3");
    txn(1, 1'b1, 3'd3, 32'h20, 32'h0, 0, "st_f3_3");
    txn(1, 1'b0, 3'd2, 32'h1000, 32'h0, 0, "lw_oob");
    txn(1, 1'b1, 3'd2, 32'h1000, 32'h0, 0, "sw_oob");
    txn(1, 1'b0, 3'd2, 32'h10, 32'h0, 5, "lw10_bp");

    // Reset during WAIT abandons the store
    txn(2, 1'b0, 3'd2, 32'h34, 32'h0, 0, "lw34");
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_funct3[2] = 3'd2;
    req_addr[2] = 32'h30; req_wdata[2] = 32'h12345678;
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("rst_mid:busy", 32'(req_ready[2]), 32'd0);
    rstd[2] = 1'b1;
    @(negedge clk);
    chk("rst_mid:req_ready", 32'(req_ready[2]), 32'd1);
    chk("rst_mid:rsp_valid", 32'(rsp_valid[2]), 32'd0);
    chk("rst_mid:rsp_rdata", rsp_rdata[2], 32'd0);
    chk("rst_mid:rsp_err", 32'(rsp_err[2]), 32'd0);
    rstd[2] = 1'b0;
    @(negedge clk);
    txn(2, 1'b0, 3'd2, 32'h30, 32'h0, 0, "lw30_after_rst");

    // Zero wait states, rsp_ready held high: one accept every two cycles
    tied[0] = 1'b1; rsp_ready[0] = 1'b1;
    c_prev = -1;
    for (int i = 0; i < 8; i++) begin
      int c_now;
      c_now = cyc;
      if (c_prev >= 0) chk("b2b:gap", 32'(c_now - c_prev), 32'd2);
      c_prev = c_now;
      txn(0, 1'(i % 2), 3'd2, 32'(($urandom_range(0, 63)) * 4), $urandom, 0, "b2b");
    end
    tied[0] = 1'b0; rsp_ready[0] = 1'b0;

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 120; i++) begin
        f3 = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) a = $urandom | 32'h1000;
        else                          a = $urandom_range(0, 255);
        txn(d, 1'($urandom_range(0, 1)), f3, a, $urandom, $urandom_range(0, 3), "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
